// File: rtl/williams_mem_pkg.sv
// Shared types and sizing helpers for the Williams memory arbiter.
package williams_mem_pkg;

    localparam int MEM_AW       = 16;
    localparam int DL_DEPTH_DEF = 4;

    // Pointer width for a power-of-two FIFO depth (depth >= 2).
    function automatic int dl_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DL_PTR_W = dl_ptr_w(DL_DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DL_ACC  = 2'd2
    } slot_t;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [7:0]        data;
    } dl_entry_t;

    localparam int DL_ENTRY_W = $bits(dl_entry_t);

    // Tag that follows each memory access down the ack pipeline.
    typedef struct packed {
        logic vld;
        logic is_cpu;
        logic is_rd;
    } acc_tag_t;

endpackage

// File: rtl/williams_dl_fifo.sv
// Download write buffer: small synchronous FIFO with occupancy count,
// registered almost-full flag and sticky overflow.
module williams_dl_fifo
    import williams_mem_pkg::*;
#(
    parameter int DEPTH = DL_DEPTH_DEF,
    localparam int PW   = dl_ptr_w(DEPTH)
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DL_ENTRY_W-1:0] din,
    output logic [DL_ENTRY_W-1:0] dout,
    output logic [PW:0]           count,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ALMOST_C = (PW+1)'(DEPTH - 1);
    localparam logic [PW:0]   ONE_C    = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_P    = PW'(1);

    logic [DL_ENTRY_W-1:0] store [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;
    logic [PW:0]           count_next;

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a coincident push.
    assign full    = (count == DEPTH_C);
    assign do_pop  = rd && (count != '0);
    assign do_push = wr && (!full || do_pop);
    assign dout    = store[rptr];

    // Next occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + ONE_C;
        end else if (do_pop && !do_push) begin
            count_next = count - ONE_C;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + ONE_P;
            if (do_pop)  rptr <= rptr + ONE_P;
            count       <= count_next;
            // One entry of slack remains for a strobe that coincides with
            // the flag rising.
            almost_full <= (count_next >= ALMOST_C);
            if (wr && full && !do_pop) overflow <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_sys) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/williams_mem_arbiter.sv
// Shares one single-port synchronous memory between the CPU (fixed
// priority) and the buffered HPS download stream, with a starvation
// escape that forces a download slot when the CPU never lets go.
module williams_mem_arbiter
    import williams_mem_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DL_DEPTH   = DL_DEPTH_DEF,
    parameter int STARVE_MAX = 15
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic          dl_busy,
    output logic          dl_overflow,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);

    localparam int PW = dl_ptr_w(DL_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);
    localparam logic [SW-1:0] ONE_S    = SW'(1);

    logic [PW:0]           fifo_count;
    logic [DL_ENTRY_W-1:0] head_bits;
    dl_entry_t             dl_in;
    dl_entry_t             dl_head;
    logic                  fifo_empty;
    logic                  dl_pop;
    logic                  cpu_take;
    slot_t                 slot;
    slot_t                 slot_next;
    acc_tag_t              tag_p1;
    acc_tag_t              tag_p2;
    logic [SW-1:0]         starve;

    assign dl_head = dl_entry_t'(head_bits);

    williams_dl_fifo #(
        .DEPTH (DL_DEPTH)
    ) u_dl_fifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .wr          (dl_wr),
        .rd          (dl_pop),
        .din         (dl_in),
        .dout        (head_bits),
        .count       (fifo_count),
        .almost_full (dl_wait),
        .overflow    (dl_overflow)
    );

    // Slot decision for this cycle: forced download, then CPU, then
    // opportunistic download drain.
    always_comb begin
        dl_in.addr = MEM_AW'(dl_addr);
        dl_in.data = dl_data;
        fifo_empty = (fifo_count == '0);
        dl_pop     = !fifo_empty && (cpu_stall || !cpu_req);
        cpu_take   = cpu_req && !(cpu_stall && !fifo_empty);
        if (dl_pop) begin
            slot_next = DL_ACC;
        end else if (cpu_take) begin
            slot_next = CPU_ACC;
        end else begin
            slot_next = IDLE;
        end
    end

    // ---- stage p1: slot owner drives the registered memory port ----
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            slot     <= IDLE;
            tag_p1   <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            slot <= slot_next;
            case (slot_next)
                DL_ACC: begin
                    tag_p1   <= '{vld: 1'b1, is_cpu: 1'b0, is_rd: 1'b0};
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b1;
                    mem_addr <= AW'(dl_head.addr);
                    mem_din  <= dl_head.data;
                end
                CPU_ACC: begin
                    tag_p1   <= '{vld: 1'b1, is_cpu: 1'b1, is_rd: !cpu_we};
                    mem_en   <= 1'b1;
                    mem_we   <= cpu_we;
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                end
                default: begin
                    tag_p1 <= '0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p2: completion tag lines up with memory read data ----
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tag_p2 <= '0;
        end else begin
            tag_p2 <= tag_p1;
        end
    end

    // Starvation counter; the stall lasts one cycle because the forced pop
    // it causes clears the counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            starve    <= '0;
            cpu_stall <= 1'b0;
        end else begin
            cpu_stall <= (starve == STARVE_C) && !dl_pop;
            if (dl_pop || fifo_empty) begin
                starve <= '0;
            end else if (starve != STARVE_C) begin
                starve <= starve + ONE_S;
            end
        end
    end

    // Read data comes straight from the memory during the ack cycle.
    assign cpu_ack  = tag_p2.vld && tag_p2.is_cpu;
    assign cpu_dout = (cpu_ack && tag_p2.is_rd) ? mem_dout : 8'h00;
    assign dl_busy  = !fifo_empty || (slot == DL_ACC);

endmodule

// File: tb/tb_williams_mem_arbiter.sv
// Bench for williams_mem_arbiter: behavioural queue model plus memory
// image, directed scenarios with literal expectations, then random traffic.
module tb_williams_mem_arbiter;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int SMAX  = 15;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          cpu_ack, cpu_stall;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait, dl_busy, dl_overflow;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout = 8'h00;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk_sys = ~clk_sys;

    williams_mem_arbiter #(.AW(AW), .DL_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wait(dl_wait), .dl_busy(dl_busy), .dl_overflow(dl_overflow),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Synchronous single-port memory image.
    logic [7:0] ram [0:65535];
    always @(posedge clk_sys) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout <= ram[mem_addr];
        end
    end

    // Behavioural model: download queue, shadow memory, starvation count.
    typedef struct packed { logic [15:0] a; logic [7:0] d; } ent_t;
    ent_t       q[$];
    logic [7:0] shadow [0:65535];
    int         starve = 0;
    bit         m_stall = 0;
    bit         e_en = 0, e_we = 0, e_ack = 0, e_stall = 0, e_wait = 0, e_busy = 0, e_ovf = 0;
    logic [15:0] e_addr = '0;
    logic [7:0]  e_din = '0, e_dout = '0;
    bit         a1_ack = 0, a1_rd = 0;
    logic [7:0] a1_data = '0;

    always @(posedge clk_sys) begin : model
        bit   pop, take;
        int   n0;
        ent_t h;
        if (reset) begin
            q.delete();
            starve = 0; m_stall = 0;
            e_en = 0; e_we = 0; e_ack = 0; e_stall = 0; e_wait = 0; e_busy = 0; e_ovf = 0;
            a1_ack = 0; a1_rd = 0;
        end else begin
            n0   = q.size();
            pop  = (n0 != 0) && (m_stall || !cpu_req);
            take = cpu_req && !pop;
            e_ack  = a1_ack;
            e_dout = a1_rd ? a1_data : 8'h00;
            a1_ack  = take;
            a1_rd   = take && !cpu_we;
            a1_data = shadow[cpu_addr];
            if (pop) begin
                h = q.pop_front();
                shadow[h.a] = h.d;
                e_en = 1; e_we = 1; e_addr = h.a; e_din = h.d;
            end else if (take) begin
                e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_din;
                if (cpu_we) shadow[cpu_addr] = cpu_din;
            end else begin
                e_en = 0; e_we = 0;
            end
            if (dl_wr) begin
                if (n0 < DEPTH || pop) q.push_back('{a: dl_addr, d: dl_data});
                else                   e_ovf = 1;
            end
            e_stall = (starve == SMAX) && !pop;
            m_stall = e_stall;
            if (pop || n0 == 0) starve = 0;
            else if (starve < SMAX) starve = starve + 1;
            e_wait = (q.size() >= DEPTH - 1);
            e_busy = (q.size() != 0) || pop;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk_sys) begin : compare
        bit bad;
        if (chk_en) begin
            tests++;
            bad = (cpu_ack !== e_ack) || (e_ack && cpu_dout !== e_dout) ||
                  (cpu_stall !== e_stall) || (dl_wait !== e_wait) || (dl_busy !== e_busy) ||
                  (dl_overflow !== e_ovf) || (mem_en !== e_en) ||
                  (e_en && ((mem_we !== e_we) || (mem_addr !== e_addr) || (e_we && mem_din !== e_din)));
            if (bad) begin
                fails++;
                $display("FAIL cycle_model t=%0t got ack=%b dout=%h stall=%b wait=%b busy=%b ovf=%b en=%b we=%b addr=%h din=%h; want ack=%b dout=%h stall=%b wait=%b busy=%b ovf=%b en=%b we=%b addr=%h din=%h",
                         $time, cpu_ack, cpu_dout, cpu_stall, dl_wait, dl_busy, dl_overflow, mem_en, mem_we, mem_addr, mem_din,
                         e_ack, e_dout, e_stall, e_wait, e_busy, e_ovf, e_en, e_we, e_addr, e_din);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        dl_wr = 0; dl_addr = '0; dl_data = '0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ack"},  cpu_ack, 0);
        chk({name, "_dout"}, cpu_dout, 0);
        chk({name, "_flags"}, {cpu_stall, dl_wait, dl_busy, dl_overflow, mem_en, mem_we}, 0);
        chk({name, "_maddr"}, mem_addr, 0);
        chk({name, "_mdin"}, mem_din, 0);
    endtask

    initial begin
        int dlp, cpup;
        bit ignore_wait;
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 8'(i) ^ 8'(i >> 8);
            shadow[i] = 8'(i) ^ 8'(i >> 8);
        end
        ram[16'h1234]    = 8'hA5;
        shadow[16'h1234] = 8'hA5;

        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk_sys);
        chk_all_zero("reset");
        reset = 0;
        chk_en = 1;
        @(negedge clk_sys);

        // CPU read of preloaded location, FIFO empty.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        @(negedge clk_sys);
        cpu_req = 0;
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 16'h1234);
        chk("rd_ack_early", cpu_ack, 0);
        @(negedge clk_sys);
        chk("rd_ack", cpu_ack, 1);
        chk("rd_dout", cpu_dout, 8'hA5);
        chk("rd_stall", cpu_stall, 0);
        @(negedge clk_sys);
        chk("rd_ack_single", cpu_ack, 0);

        // Four download bytes with the CPU idle.
        dl_wr = 1; dl_addr = 16'h0000; dl_data = 8'h10;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_sys);
            if (k < 4) begin dl_addr = 16'(k); dl_data = 8'(8'h10 + k); end
            if (k == 4) dl_wr = 0;
            chk("dl4_wait", dl_wait, 0);
            if (k >= 2 && k <= 5) begin
                chk("dl4_en_we", {mem_en, mem_we}, 2'b11);
                chk("dl4_addr", mem_addr, 32'(k - 2));
                chk("dl4_din", mem_din, 32'(8'h10 + k - 2));
            end
            if (k == 5) chk("dl4_busy_hold", dl_busy, 1);
            if (k == 6) chk("dl4_busy_fall", dl_busy, 0);
        end

        // Starvation: CPU holds the port, one byte waits for a forced slot.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        dl_wr = 1; dl_addr = 16'h8000; dl_data = 8'h5A;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk_sys);
            if (k == 1)  dl_wr = 0;
            if (k == 16) chk("stv_stall_pre", cpu_stall, 0);
            if (k == 17) begin
                chk("stv_stall", cpu_stall, 1);
                chk("stv_model_stall", e_stall, 1);
            end
            if (k == 18) begin
                chk("stv_stall_post", cpu_stall, 0);
                chk("stv_wr_en_we", {mem_en, mem_we}, 2'b11);
                chk("stv_wr_addr", mem_addr, 16'h8000);
                chk("stv_wr_din", mem_din, 8'h5A);
                chk("stv_ack_before", cpu_ack, 1);
            end
            if (k == 19) begin
                chk("stv_cpu_resume", {mem_en, mem_we}, 2'b10);
                chk("stv_ack_gap", cpu_ack, 0);
            end
            if (k == 20) chk("stv_ack_resume", cpu_ack, 1);
        end
        cpu_req = 0;
        repeat (3) @(negedge clk_sys);

        // Overflow: six strobes while the CPU holds the port.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
        dl_wr = 1; dl_addr = 16'h9000; dl_data = 8'h20;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_sys);
            if (k <= 3) begin dl_addr = 16'(16'h9000 + k); dl_data = 8'(8'h20 + k); end
            if (k == 2) chk("ovf_wait_low", dl_wait, 0);
            if (k == 3) chk("ovf_wait_high", dl_wait, 1);
            if (k == 4) dl_wr = 0;
            if (k == 17) begin
                chk("ovf_stall", cpu_stall, 1);
                dl_wr = 1; dl_addr = 16'h9004; dl_data = 8'h24;
            end
            if (k == 18) begin
                chk("ovf_full_pushpop", dl_overflow, 0);
                chk("ovf_wait_full", dl_wait, 1);
                chk("ovf_pop_addr", mem_addr, 16'h9000);
                dl_addr = 16'h9005; dl_data = 8'h25;
            end
            if (k == 19) begin
                dl_wr = 0;
                chk("ovf_set", dl_overflow, 1);
            end
            if (k == 20) cpu_req = 0;
            if (k == 24) begin
                chk("ovf_fifth_addr", mem_addr, 16'h9004);
                chk("ovf_fifth_din", mem_din, 8'h24);
            end
            if (k == 25) chk("ovf_sixth_dropped", mem_en, 0);
            if (k == 30) chk("ovf_sticky", dl_overflow, 1);
        end

        // Reset with a CPU read in flight and two queued bytes.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        dl_wr = 1; dl_addr = 16'hA000; dl_data = 8'h30;
        @(negedge clk_sys);
        dl_addr = 16'hA001; dl_data = 8'h31;
        @(negedge clk_sys);
        idle_inputs();
        reset = 1;
        @(negedge clk_sys);
        chk_all_zero("rst_mid");
        reset = 0;
        @(negedge clk_sys);
        chk("rst_no_ack", cpu_ack, 0);
        chk("rst_fifo_empty", {dl_busy, mem_en}, 0);
        @(negedge clk_sys);
        chk("rst_no_ack2", cpu_ack, 0);
        chk("rst_fifo_empty2", {dl_busy, mem_en}, 0);

        // Random traffic over a small address window so downloads and CPU
        // reads/writes overlap.
        for (int ph = 0; ph < 8; ph++) begin
            cpup = (ph % 4 == 1) ? 97 : (ph % 4 == 2) ? 20 : 60;
            dlp  = (ph % 2 == 0) ? 70 : 30;
            ignore_wait = (ph % 3 == 2);
            for (int n = 0; n < 500; n++) begin
                @(negedge clk_sys);
                reset    = ($urandom_range(0, 599) == 0);
                cpu_req  = ($urandom_range(0, 99) < cpup);
                cpu_we   = $urandom_range(0, 1);
                cpu_addr = 16'($urandom_range(0, 31));
                cpu_din  = 8'($urandom);
                dl_wr    = ($urandom_range(0, 99) < dlp) && (ignore_wait || !dl_wait);
                dl_addr  = 16'($urandom_range(0, 31));
                dl_data  = 8'($urandom);
            end
        end
        idle_inputs();
        reset = 0;
        repeat (10) @(negedge clk_sys);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/williams_mem_arbiter.md
Name: williams_mem_arbiter

Overview:
- Shares one single-port synchronous memory (program ROM / video RAM image) between the CPU and the HPS ROM-download stream.
- The CPU has fixed priority. Download writes are buffered in a small FIFO, drained into idle memory cycles, and backpressured with ioctl_wait.
- A starvation counter forces a download slot when the CPU never releases the port.
- Sits between williams_soc memory signals, the ioctl bus, and the memory instance.

Parameters:
- AW, 16, memory address width.
- DL_DEPTH, 4, download FIFO depth in entries (power of 2, minimum 2).
- STARVE_MAX, 15, consecutive cycles the FIFO may be non-empty without a pop before a download slot is forced.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high. Must not include rom_download.
- cpu_req  in  1  CPU access request; held until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  this cycle's slot belongs to download; cpu_req is not accepted.
- dl_wr  in  1  download byte strobe.
- dl_addr  in  AW  download address.
- dl_data  in  8  download byte.
- dl_wait  out  1  drives ioctl_wait.
- dl_busy  out  1  FIFO non-empty or a download write is in flight.
- dl_overflow  out  1  sticky: a dl_wr arrived while the FIFO was full.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data, valid one cycle after mem_en.

Behaviour:
- Reset values:
  - cpu_ack, cpu_stall, dl_wait, dl_busy, dl_overflow, mem_en, mem_we = 0.
  - cpu_dout, mem_addr, mem_din = 0.
  - FIFO empty; starvation counter 0.
- Reset mid-operation: in-flight accesses are abandoned and no ack is issued afterwards.
- Slot decision is made each cycle T, based only on registered state:
  - If cpu_stall=1 and the FIFO is non-empty: pop the FIFO head and issue a write.
  - Else if cpu_req=1: accept the CPU access.
  - Else if the FIFO is non-empty: pop and write.
  - Else: idle.
- Memory outputs (mem_en/we/addr/din) are registered and driven in cycle T+1.
- CPU timing:
  - Accepted in T; mem_en in T+1; cpu_ack=1 in T+2 for both reads and writes.
  - For reads, cpu_dout = mem_dout captured at T+2.
  - At most one CPU access is accepted per cycle, back-to-back allowed.
  - The requester may drop cpu_req after T; a held req in T+1 counts as a new access.
- Download FIFO:
  - Push on dl_wr when count < DL_DEPTH.
  - Push and pop in the same cycle are legal at any count, including full.
  - dl_wr while full with no pop: byte dropped, dl_overflow set until reset.
- dl_wait: registered, = (count >= DL_DEPTH-1) after the update. This leaves one entry of slack for a strobe coincident with dl_wait rising.
- dl_busy: = (count != 0) | (download write in T+1 stage).
- Starvation:
  - Counter increments each cycle with count != 0 and no pop; clears on any pop or when empty.
  - When counter == STARVE_MAX, cpu_stall=1 in the next cycle for exactly one cycle, which forces a pop.
  - cpu_stall never asserts when the FIFO is empty.
- Arithmetic:
  - FIFO pointers are log2(DL_DEPTH) bits and wrap naturally.
  - count is log2(DL_DEPTH)+1 bits.
  - Starvation counter saturates at STARVE_MAX.
- State machine for slot ownership (registered): IDLE, CPU_ACC, DL_ACC.
  - Any state moves to CPU_ACC, DL_ACC or IDLE per the slot decision each cycle. There are no multi-cycle holds.
  - A 2-stage pipeline of {valid, is_cpu, is_read} tags carries ack generation.

Decomposition:
- Package williams_mem_pkg:
  - slot_t enum {IDLE, CPU_ACC, DL_ACC}.
  - Localparam for FIFO pointer width derived from DL_DEPTH.
  - dl_entry_t struct {addr[AW], data[8]}.
- Sub-module williams_dl_fifo holds the synchronous FIFO with count, full, almost_full and overflow. The arbiter instantiates it once.

Test Plan:
- CPU read at 0x1234 with memory preloaded 0xA5, FIFO empty -> mem_en/mem_addr=0x1234 at T+1; cpu_ack=1 with cpu_dout=0xA5 at T+2; cpu_stall stays 0.
- 4 consecutive dl_wr to 0x0000..0x0003 (data 0x10..0x13) with CPU idle -> written in order on 4 consecutive mem cycles; dl_wait never blocks; dl_busy falls 2 cycles after the last pop.
- cpu_req held continuously, one dl_wr to 0x8000 -> after 15 non-pop cycles cpu_stall=1 for one cycle; memory write of 0x8000 issued; CPU accesses resume the following cycle with no lost ack.
- Download burst of 6 strobes ignoring dl_wait while cpu_req is held -> dl_wait=1 once count reaches 3; the 5th strobe is stored and the 6th is dropped; dl_overflow=1 and sticky.
- Reset asserted one cycle after a CPU read is accepted and with 2 FIFO entries -> no cpu_ack; FIFO empty; all outputs 0 the cycle after reset.
- Simultaneous dl_wr and pop with FIFO full (count=4) -> count stays 4; no overflow; ordering preserved.
